// File: rtl/ddr_wr_scheduler.sv
// Write-burst scheduler: drains a first-word-fall-through FIFO into DDR write bursts
// inside a ring region. It issues full bursts, or flushes a partial burst once the FIFO has been idle.
module ddr_wr_scheduler #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 28,
  parameter int unsigned FIFO_CNT_W    = 10,
  parameter int unsigned BURST_LEN     = 16,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned REGION_WORDS  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [FIFO_CNT_W-1:0] i_fifo_count,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_cmd_addr,
  output logic [7:0]            o_cmd_len,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_wr_last,
  output logic                  o_busy,
  output logic                  o_wrap,
  output logic [31:0]           o_words_written
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(REGION_WORDS + 1);
  localparam int unsigned TMR_W  = $clog2(FLUSH_TIMEOUT + 1);
  localparam int unsigned BEAT_W = 9;

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [FIFO_CNT_W-1:0]   cnt_prev_q, cnt_prev_d;
  logic [BEAT_W-1:0]       beats_q, beats_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [7:0]              cmd_len_q, cmd_len_d;
  logic                    wrap_q, wrap_d;
  logic [31:0]             words_q, words_d;

  logic [31:0]           cnt32;
  logic                  full;
  logic                  flush_hit;
  logic                  start;
  logic                  timer_run;
  logic [31:0]           req_beats;
  logic [31:0]           room;
  logic [31:0]           start_beats;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [31:0]           offset_sum;
  logic                  wr_valid;
  logic                  wr_accept;
  logic                  wr_is_last;

  assign cnt32     = 32'(i_fifo_count);
  assign full      = cnt32 >= BURST_LEN;
  assign flush_hit = (32'(timer_q) == FLUSH_TIMEOUT - 1) && !i_fifo_empty && (cnt32 != 0);
  assign start     = i_enable && (full || flush_hit);

  // The timer only advances while the fill level is stable and short of a full burst.
  assign timer_run = i_enable && !i_fifo_empty && !full && (i_fifo_count == cnt_prev_q) &&
                     (32'(timer_q) < FLUSH_TIMEOUT - 1);

  // Clip the burst so it never runs past the end of the ring region.
  assign req_beats   = full ? BURST_LEN : cnt32;
  assign room        = REGION_WORDS - 32'(offset_q);
  assign start_beats = (req_beats < room) ? req_beats : room;
  assign start_addr  = BASE_ADDR + ADDR_WIDTH'(32'(offset_q) * BYTES);
  assign offset_sum  = 32'(offset_q) + 32'(beats_q);

  assign wr_valid   = (state_q == StWrite) && !i_fifo_empty;
  assign wr_accept  = wr_valid && i_wr_ready;
  assign wr_is_last = (beat_q == beats_q - BEAT_W'(1));

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    timer_d     = '0;
    cnt_prev_d  = i_fifo_count;
    beats_d     = beats_q;
    beat_d      = beat_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wrap_d      = 1'b0;
    words_d     = words_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StCmd;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = start_addr;
          cmd_len_d   = 8'(start_beats - 32'd1);
          beats_d     = BEAT_W'(start_beats);
          beat_d      = '0;
        end else if (timer_run) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      StCmd: begin
        if (i_cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        if (wr_accept) begin
          if (wr_is_last) begin
            beat_d  = '0;
            state_d = StUpdate;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      StUpdate: begin
        words_d = words_q + 32'(beats_q);
        if (offset_sum == REGION_WORDS) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = OFF_W'(offset_sum);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      timer_q     <= '0;
      cnt_prev_q  <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= BASE_ADDR;
      cmd_len_q   <= '0;
      wrap_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      timer_q     <= timer_d;
      cnt_prev_q  <= cnt_prev_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      wrap_q      <= wrap_d;
      words_q     <= words_d;
    end
  end

  assign o_fifo_rd_en    = wr_accept;
  assign o_cmd_valid     = cmd_valid_q;
  assign o_cmd_addr      = cmd_addr_q;
  assign o_cmd_len       = cmd_len_q;
  assign o_wr_valid      = wr_valid;
  assign o_wr_data       = i_fifo_data;
  assign o_wr_last       = wr_valid && wr_is_last;
  assign o_busy          = (state_q != StIdle);
  assign o_wrap          = wrap_q;
  assign o_words_written = words_q;

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// Scoreboard bench for ddr_wr_scheduler: a FWFT FIFO model feeds the DUT, stimulus queues expected
// commands and beats, and a negedge monitor pops and compares every handshake.
module tb_ddr_wr_scheduler;

  typedef struct packed {
    logic [27:0] addr;
    logic [7:0]  len;
  } cmd_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [9:0]  i_fifo_count;
  logic        i_fifo_empty;
  logic [15:0] i_fifo_data;
  logic        o_fifo_rd_en;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [27:0] o_cmd_addr;
  logic [7:0]  o_cmd_len;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [15:0] o_wr_data;
  logic        o_wr_last;
  logic        o_busy;
  logic        o_wrap;
  logic [31:0] o_words_written;

  ddr_wr_scheduler #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (28),
    .FIFO_CNT_W   (10),
    .BURST_LEN    (16),
    .FLUSH_TIMEOUT(8),
    .BASE_ADDR    (28'h0),
    .REGION_WORDS (40)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_fifo_count   (i_fifo_count),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_data    (i_fifo_data),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .o_cmd_valid    (o_cmd_valid),
    .i_cmd_ready    (i_cmd_ready),
    .o_cmd_addr     (o_cmd_addr),
    .o_cmd_len      (o_cmd_len),
    .o_wr_valid     (o_wr_valid),
    .i_wr_ready     (i_wr_ready),
    .o_wr_data      (o_wr_data),
    .o_wr_last      (o_wr_last),
    .o_busy         (o_busy),
    .o_wrap         (o_wrap),
    .o_words_written(o_words_written)
  );

  always #5 i_clk = ~i_clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cmd_seen = 0;
  int    beat_seen = 0;
  int    wrap_cnt = 0;
  cmd_t  exp_cmd[$];
  beat_t exp_beat[$];
  logic [15:0] fifo[$];
  logic [15:0] pend[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) pend.push_back(base + 16'(i));
  endtask

  task automatic expect_burst(input logic [27:0] addr, input int n, input logic [15:0] base);
    cmd_t c;
    beat_t b;
    c.addr = addr;
    c.len  = 8'(n - 1);
    exp_cmd.push_back(c);
    for (int i = 0; i < n; i++) begin
      b.data = base + 16'(i);
      b.last = (i == n - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic wait_beats(input int target, input string name);
    int k;
    for (k = 0; k < 600; k++) begin
      if (beat_seen >= target) break;
      tick();
    end
    if (k == 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, beats got %0d expected %0d", name, beat_seen, target);
    end
  endtask

  task automatic wait_cmd_valid(input string name, output int cycles);
    cycles = 0;
    while (!o_cmd_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!o_cmd_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for o_cmd_valid", name);
    end
  endtask

  // FWFT FIFO model: pops on the rd_en seen before the edge, pushes one queued word per cycle.
  initial begin
    logic rd;
    i_fifo_count = '0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    forever begin
      @(negedge i_clk);
      rd = o_fifo_rd_en;
      @(posedge i_clk);
      #1;
      if (rd && fifo.size() > 0) void'(fifo.pop_front());
      if (pend.size() > 0) fifo.push_back(pend.pop_front());
      i_fifo_count = 10'(fifo.size());
      i_fifo_empty = (fifo.size() == 0);
      i_fifo_data  = (fifo.size() > 0) ? fifo[0] : 16'h0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    cmd_t  c;
    beat_t b;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_cmd_valid) begin
          if (exp_cmd.size() == 0) begin
            if (i_cmd_ready) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_cmd: got addr 0x%0h len %0d expected none",
                       o_cmd_addr, o_cmd_len);
            end
          end else begin
            c = exp_cmd[0];
            check("cmd_addr", 64'(o_cmd_addr), 64'(c.addr));
            check("cmd_len", 64'(o_cmd_len), 64'(c.len));
            if (i_cmd_ready) begin
              void'(exp_cmd.pop_front());
              cmd_seen++;
            end
          end
        end
        if (o_fifo_rd_en || (o_wr_valid && i_wr_ready))
          check("rd_en_vs_accept", 64'(o_fifo_rd_en), 64'(o_wr_valid && i_wr_ready));
        if (o_wr_valid && i_wr_ready) begin
          if (exp_beat.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h expected none", o_wr_data);
          end else begin
            b = exp_beat.pop_front();
            check("beat_data", 64'(o_wr_data), 64'(b.data));
            check("beat_last", 64'(o_wr_last), 64'(b.last));
          end
          beat_seen++;
        end
        if (o_wrap) wrap_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int wrap0;
    i_rst       = 1'b1;
    i_enable    = 1'b0;
    i_cmd_ready = 1'b1;
    i_wr_ready  = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_cmd_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_cmd_addr", 64'(o_cmd_addr), 64'd0);
    check("rst_words", 64'(o_words_written), 64'd0);
    i_rst    = 1'b0;
    i_enable = 1'b1;
    tick();

    // Full burst of 16 at offset 0.
    expect_burst(28'h0, 16, 16'h0001);
    push_words(16'h0001, 16);
    wait_beats(16, "t1_beats");
    check("t1_busy_in_update", 64'(o_busy), 64'd1);
    tick();
    check("t1_busy_low", 64'(o_busy), 64'd0);
    check("t1_words", 64'(o_words_written), 64'd16);
    check("t1_cmd_count", 64'(cmd_seen), 64'd1);

    // Partial flush of 3 words at offset 16.
    expect_burst(28'h20, 3, 16'h0101);
    push_words(16'h0101, 3);
    for (int k = 0; k < 20 && pend.size() > 0; k++) tick();
    wait_cmd_valid("t2_cmd", cyc);
    check("t2_flush_latency_ok", 64'(cyc >= 9 && cyc <= 10), 64'd1);
    wait_beats(19, "t2_beats");
    tick();
    check("t2_words", 64'(o_words_written), 64'd19);

    // Backpressure on command then every-other-cycle data ready, offset 19.
    i_cmd_ready = 1'b0;
    expect_burst(28'h26, 16, 16'h0201);
    push_words(16'h0201, 16);
    wait_cmd_valid("t3_cmd", cyc);
    repeat (5) tick();
    check("t3_cmd_not_taken", 64'(cmd_seen), 64'd2);
    check("t3_cmd_held", 64'(o_cmd_valid), 64'd1);
    i_cmd_ready = 1'b1;
    for (int k = 0; k < 200 && beat_seen < 35; k++) begin
      i_wr_ready = ~i_wr_ready;
      tick();
    end
    i_wr_ready = 1'b1;
    wait_beats(35, "t3_beats");
    tick();
    check("t3_words", 64'(o_words_written), 64'd35);

    // Reset from idle clears offset and the word counter.
    i_rst = 1'b1;
    #1;
    check("r1_words", 64'(o_words_written), 64'd0);
    check("r1_addr", 64'(o_cmd_addr), 64'd0);
    tick();
    i_rst = 1'b0;
    tick();

    // Wrap: 16@0x0, 16@0x20, 8@0x40 (clipped), wrap, then 8 flushed at 0x0.
    wrap0 = wrap_cnt;
    expect_burst(28'h00, 16, 16'h0301);
    expect_burst(28'h20, 16, 16'h0311);
    expect_burst(28'h40, 8, 16'h0321);
    expect_burst(28'h00, 8, 16'h0329);
    push_words(16'h0301, 48);
    wait_beats(83, "t4_beats");
    tick();
    check("t4_wrap_pulses", 64'(wrap_cnt - wrap0), 64'd1);
    check("t4_words", 64'(o_words_written), 64'd48);

    // Reset after beat 5 of a 16-beat burst at offset 8.
    expect_burst(28'h10, 16, 16'h0401);
    push_words(16'h0401, 16);
    wait_beats(88, "t5_first_beats");
    i_rst = 1'b1;
    #1;
    check("t5_cmd_valid", 64'(o_cmd_valid), 64'd0);
    check("t5_wr_valid", 64'(o_wr_valid), 64'd0);
    check("t5_rd_en", 64'(o_fifo_rd_en), 64'd0);
    check("t5_wr_last", 64'(o_wr_last), 64'd0);
    check("t5_busy", 64'(o_busy), 64'd0);
    check("t5_wrap", 64'(o_wrap), 64'd0);
    check("t5_addr", 64'(o_cmd_addr), 64'd0);
    check("t5_len", 64'(o_cmd_len), 64'd0);
    check("t5_words", 64'(o_words_written), 64'd0);
    exp_cmd.delete();
    exp_beat.delete();
    tick();
    tick();
    i_rst = 1'b0;
    expect_burst(28'h00, 11, 16'h0406);
    wait_beats(99, "t5_fresh_beats");
    tick();
    check("t5_words_after", 64'(o_words_written), 64'd11);

    // Enable drop during CMD: burst completes, nothing new starts while disabled.
    i_cmd_ready = 1'b0;
    expect_burst(28'h16, 16, 16'h0501);
    push_words(16'h0501, 16);
    wait_cmd_valid("t6_cmd", cyc);
    i_enable = 1'b0;
    repeat (3) tick();
    check("t6_cmd_held", 64'(o_cmd_valid), 64'd1);
    i_cmd_ready = 1'b1;
    wait_beats(115, "t6_beats");
    tick();
    check("t6_words", 64'(o_words_written), 64'd27);
    push_words(16'h0601, 16);
    repeat (60) tick();
    check("t6_idle", 64'(o_busy), 64'd0);
    check("t6_cmd_count", 64'(cmd_seen), 64'd10);
    check("end_cmd_queue", 64'(exp_cmd.size()), 64'd0);
    check("end_beat_queue", 64'(exp_beat.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_wr_scheduler.md
Name: ddr_wr_scheduler

Overview:
- Sequences packed words from the write FIFO into DDR write bursts; sits between the FIFO and the DDR write-command/data interface, downstream of the byte packetizer.
- Issues a full burst when the FIFO holds at least BURST_LEN words; a partial flush burst when data has been idle in the FIFO for FLUSH_TIMEOUT cycles.
- Generates linear DDR addresses inside a ring region and wraps at the region end.

Parameters:
- DATA_WIDTH, 16, FIFO/DDR word width in bits; multiple of 8.
- ADDR_WIDTH, 28, DDR byte-address width.
- FIFO_CNT_W, 10, width of the FIFO fill-count input.
- BURST_LEN, 16, maximum beats per burst; range 1..256.
- FLUSH_TIMEOUT, 1024, idle cycles before a partial burst is flushed; at least 1.
- BASE_ADDR, 0, byte address of region start; aligned to DATA_WIDTH/8.
- REGION_WORDS, 4096, ring region size in words.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_enable, input, 1, allows new bursts to start.
- i_fifo_count, input, FIFO_CNT_W, words currently in the FIFO.
- i_fifo_empty, input, 1, FIFO empty.
- i_fifo_data, input, DATA_WIDTH, FIFO head word (first-word-fall-through).
- o_fifo_rd_en, output, 1, pops the FIFO head.
- o_cmd_valid, output, 1, write command valid.
- i_cmd_ready, input, 1, DDR accepts the command.
- o_cmd_addr, output, ADDR_WIDTH, burst start byte address.
- o_cmd_len, output, 8, beats minus 1.
- o_wr_valid, output, 1, write data valid.
- i_wr_ready, input, 1, DDR accepts the data beat.
- o_wr_data, output, DATA_WIDTH, write data.
- o_wr_last, output, 1, final beat of the burst.
- o_busy, output, 1, state is not IDLE.
- o_wrap, output, 1, one-cycle pulse when the address wraps to BASE_ADDR.
- o_words_written, output, 32, total beats accepted by DDR; wraps modulo 2^32.

Behaviour:
- Reset (async, i_rst=1):
  - State is IDLE; offset, timer, beat counter and o_words_written are 0.
  - All outputs are 0, except o_cmd_addr = BASE_ADDR.
  - FIFO contents are untouched. Reset mid-burst abandons the burst; no o_wr_last is issued.
- States: IDLE, CMD, WRITE, UPDATE.
- IDLE, flush timer:
  - Counts up when i_enable=1, i_fifo_empty=0 and i_fifo_count < BURST_LEN.
  - Clears when the FIFO is empty, when i_fifo_count differs from its value in the previous cycle, or when a burst starts.
- IDLE, start rule (if i_enable=1):
  - Full burst: i_fifo_count >= BURST_LEN → beats = BURST_LEN.
  - Flush burst: timer == FLUSH_TIMEOUT-1 → beats = i_fifo_count.
  - In both cases, beats = min(beats, REGION_WORDS - offset).
  - beats is latched; o_cmd_len = beats-1; o_cmd_addr = BASE_ADDR + offset*(DATA_WIDTH/8).
  - Next state is CMD, with o_cmd_valid=1 on the following cycle.
- CMD:
  - Hold o_cmd_valid, addr and len stable until i_cmd_ready=1, then go to WRITE.
  - i_enable dropping in CMD does not cancel the command.
- WRITE:
  - o_wr_valid = !i_fifo_empty; o_wr_data = i_fifo_data.
  - o_fifo_rd_en = o_wr_valid & i_wr_ready. A beat is accepted only on that condition.
  - o_wr_last = o_wr_valid & (beat counter == beats-1).
  - On an accepted last beat, go to UPDATE. FIFO underflow only stalls the burst; it never aborts it.
- UPDATE (1 cycle):
  - offset += beats; o_words_written += beats.
  - If the new offset == REGION_WORDS, set offset to 0 and pulse o_wrap.
  - Return to IDLE.
  - Back-to-back bursts: IDLE→CMD takes one cycle, so burst-to-burst gap is at least 2 cycles after the last beat.
- i_enable=0: the current burst completes; no new burst starts and the timer holds at 0.
- Arithmetic:
  - offset is clog2(REGION_WORDS+1) bits.
  - Address sum is truncated to ADDR_WIDTH.
  - beats never exceeds BURST_LEN; a burst never crosses the region end.

Test Plan:
- Full burst: fill 16 words 0x0001..0x0010, BURST_LEN=16, ready always high → one cmd (addr 0x0, len 15), 16 beats in order, o_wr_last on 0x0010, o_words_written=16, o_busy low two cycles after the last beat.
- Flush: push 3 words then idle, FLUSH_TIMEOUT=8 → cmd appears 9-10 cycles after the last push with len 2 and addr = prior offset*2; 3 beats accepted.
- Backpressure: hold i_cmd_ready low 5 cycles, then toggle i_wr_ready every other cycle → cmd fields stable throughout; o_fifo_rd_en only on accepted beats; data order preserved.
- Wrap/truncate: REGION_WORDS=40, BURST_LEN=16, supply 48 words → bursts of 16,16,8 at byte addrs 0x0, 0x20, 0x40; o_wrap pulses after the third burst; next burst at 0x0.
- Reset mid-burst: assert i_rst after beat 5 of 16 → all outputs 0 asynchronously; after release, state is IDLE, addr = BASE_ADDR, o_words_written=0, remaining FIFO words are issued in a fresh burst.
- Enable drop: deassert i_enable during CMD → burst completes; no further cmd while disabled even with the FIFO count >= 16.
